// File: rtl/rv32m_arbiter.sv
// rtl/rv32m_arbiter.sv - round-robin sequencer sharing one rv32m multiply/divide unit between two requesters
// Optional WAIT-state timeout is enabled by defining RV32M_ARB_TIMEOUT_EN.
module rv32m_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_funct3,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_rd,
  output logic            rsp0_error,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_funct3,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_rd,
  output logic            rsp1_error,
  output logic            m_in_valid,
  output logic [2:0]      m_funct3,
  output logic [XLEN-1:0] m_rs1,
  output logic [XLEN-1:0] m_rs2,
  input  logic [XLEN-1:0] m_rd,
  input  logic            m_out_valid,
  input  logic            m_in_error,
  output logic            busy,
  output logic            grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic            prio;
  logic            grant;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] rd0_q, rd1_q;
  logic            err0_q, err1_q;
  logic            any_req, win1, accept, capture, timeout_hit;
  logic [XLEN-1:0] cap_rd;
  logic            cap_err;

  // prio only matters when both requesters contend
  assign any_req = req0_valid | req1_valid;
  assign win1    = req1_valid & (~req0_valid | prio);
  assign accept  = (state == IDLE) & ~rst & any_req;

  assign req0_ready = accept & ~win1;
  assign req1_ready = accept & win1;

`ifdef RV32M_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  assign timeout_hit = (state == WAIT) & ~m_out_valid & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // a real result in the same cycle as the timeout takes precedence
  assign capture = (state == WAIT) & (m_out_valid | timeout_hit);
  assign cap_rd  = m_out_valid ? m_rd : '0;
  assign cap_err = m_out_valid ? m_in_error : 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (capture) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      grant  <= 1'b0;
      f3_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant <= win1;
        prio  <= ~win1;
        f3_q  <= win1 ? req1_funct3 : req0_funct3;
        rs1_q <= win1 ? req1_rs1 : req0_rs1;
        rs2_q <= win1 ? req1_rs2 : req0_rs2;
      end
      // per-port result registers so each port keeps its last result
      if (capture) begin
        if (grant) begin
          rd1_q  <= cap_rd;
          err1_q <= cap_err;
        end else begin
          rd0_q  <= cap_rd;
          err0_q <= cap_err;
        end
      end
    end
  end

  assign m_in_valid = (state == ISSUE);
  assign m_funct3   = f3_q;
  assign m_rs1      = rs1_q;
  assign m_rs2      = rs2_q;
  assign rsp0_valid = (state == RESP) & ~grant;
  assign rsp1_valid = (state == RESP) & grant;
  assign rsp0_rd    = rd0_q;
  assign rsp0_error = err0_q;
  assign rsp1_rd    = rd1_q;
  assign rsp1_error = err1_q;
  assign busy       = (state != IDLE);
  assign grant_id   = grant;

endmodule

// File: doc/rv32m_arbiter.md
Name: rv32m_arbiter

Overview:
- Sequencer and arbiter that shares one rv32m multiply/divide unit between two requesters, e.g. the integer pipeline (port 0) and a debug/test port (port 1).
- Accepts one operation at a time through a valid/ready handshake and grants requesters round-robin.
- Drives the unit's in_valid/funct3/rs1/rs2 and waits for its out_valid.
- Returns rd and the error flag to the requester that issued the operation.

Parameters:
- XLEN, 32, operand/result width.
- TIMEOUT, 64, WAIT-state cycle limit; used only when RV32M_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU).
- req0_rs1, req0_rs2  in  XLEN  operands.
- rsp0_valid  out  1  one-cycle pulse when the result for requester 0 is available.
- rsp0_rd  out  XLEN  result.
- rsp0_error  out  1  unit in_error, or timeout.
- req1_*/rsp1_*  same as port 0, for requester 1.
- m_in_valid  out  1  start pulse to the rv32m unit.
- m_funct3  out  3  operation select to the unit.
- m_rs1, m_rs2  out  XLEN  operands to the unit.
- m_rd  in  XLEN  unit result.
- m_out_valid  in  1  unit result valid.
- m_in_error  in  1  unit error flag.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  owner of the current or last operation.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, prio pointer 0, grant_id 0, timeout counter 0, operand registers 0.
- IDLE:
  - reqX_ready is combinational and high only for the winner, only in IDLE.
  - Winner: if exactly one reqX_valid is high, that requester wins. If both are high, the requester selected by prio wins.
  - On handshake: latch funct3/rs1/rs2, set grant_id to the winner, set prio to the other requester, go to ISSUE.
- ISSUE:
  - m_in_valid=1 for exactly one cycle; the next state is WAIT.
  - m_funct3/m_rs1/m_rs2 are driven from the latched registers and held stable from ISSUE through RESP.
  - m_out_valid is ignored in this state.
- WAIT:
  - On m_out_valid=1: capture m_rd and m_in_error, go to RESP.
- RESP:
  - rspG_valid=1 for exactly one cycle, where G=grant_id. rspG_rd/rspG_error hold the captured values.
  - Next state is IDLE. A new handshake is possible in the cycle after RESP.
- rsp_rd/rsp_error hold their last value after the pulse. The response has no ready; requesters must sample on the pulse.
- Minimum latency: handshake at cycle N, m_in_valid at N+1, m_out_valid at N+k (k>=2), rsp_valid at N+k+1.
- Boundary conditions:
  - m_out_valid in IDLE or RESP is ignored.
  - The non-granted requester's valid stays pending, with ready low, until the next IDLE.
  - rst asserted in any state returns to IDLE next edge. The in-flight operation is dropped: no rsp pulse, m_in_valid low, prio cleared to 0.
  - funct3 is passed through unchanged. Divide-by-zero/overflow results are whatever the unit returns.

Optional Feature:
- Macro RV32M_ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and incremented each WAIT cycle.
  - If it reaches TIMEOUT without m_out_valid: go to RESP with rd=0, error=1.
  - m_out_valid and the timeout in the same cycle: the real result wins.
- Not defined: no counter; WAIT lasts until m_out_valid.

Test Plan:
- Single op: req0 MUL rs1=0x00000007, rs2=0x00000006, unit returns 0x2A after 3 cycles -> m_in_valid 1 cycle after handshake, rsp0_valid 1 cycle after m_out_valid, rsp0_rd=0x0000002A, rsp0_error=0, rsp1_valid stays 0.
- Contention: both valid from reset (prio=0) with req0 DIVU 100/7 and req1 REMU 100/7 -> req0 granted first, rd=14; req1 granted next, rd=2; grant_id sequence 0,1.
- Round-robin fairness: both held valid for 6 operations -> grants alternate 0,1,0,1,0,1 and no port is starved.
- Error pass-through: unit asserts m_in_error=1 with m_rd=0xFFFFFFFF for DIV x/0 -> rspG_error=1, rspG_rd=0xFFFFFFFF.
- Reset mid-op: rst for one cycle during WAIT -> next cycle busy=0, no rsp pulse, prio=0; subsequent req1 op completes normally.
- Timeout (macro defined, TIMEOUT=8): unit never raises m_out_valid -> rsp pulse after 8 WAIT cycles with rd=0, error=1. Without the macro, busy stays 1 for 200 cycles.
